// File: rtl/sw_array_ctrl_if.sv
// Job/host and PE-0 bundle for the Smith-Waterman array sequencer.
// The slave side is the sequencer; the master side is the host, buffer and PE chain.
interface sw_array_ctrl_if #(
    parameter int WIDTH           = 10,
    parameter int REF_LEN_WIDTH   = 10,
    parameter int QUERY_LEN_WIDTH = 10
);
    logic                       start;
    logic                       ready;
    logic                       busy;
    logic [REF_LEN_WIDTH-1:0]   ref_len_in;
    logic [QUERY_LEN_WIDTH-1:0] query_len_in;
    logic [7*WIDTH-1:0]         score_params_in;
    logic [7*WIDTH-1:0]         score_params_out;
    logic                       set_param;
    logic                       last;
    logic                       ref_rd_en;
    logic [REF_LEN_WIDTH-1:0]   ref_rd_addr;
    logic [2:0]                 ref_rd_data;
    logic [2:0]                 T_out;
    logic                       init_out;
    logic [WIDTH-1:0]           init_V;
    logic [WIDTH-1:0]           init_E;
    logic                       compute_max;
    logic [QUERY_LEN_WIDTH-1:0] block_idx;
    logic                       done;

    modport master (
        output start, ref_len_in, query_len_in, score_params_in, ref_rd_data,
        input  ready, busy, score_params_out, set_param, last, ref_rd_en, ref_rd_addr,
               T_out, init_out, init_V, init_E, compute_max, block_idx, done
    );

    modport slave (
        input  start, ref_len_in, query_len_in, score_params_in, ref_rd_data,
        output ready, busy, score_params_out, set_param, last, ref_rd_en, ref_rd_addr,
               T_out, init_out, init_V, init_E, compute_max, block_idx, done
    );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman PE array: splits the query into NUM_PE-row
// blocks, streams the reference through PE 0 per block, then runs max-reduction.
module sw_array_ctrl #(
    parameter int WIDTH           = 10,
    parameter int REF_LEN_WIDTH   = 10,
    parameter int QUERY_LEN_WIDTH = 10,
    parameter int NUM_PE          = 4,
    parameter int LOG_NUM_PE      = 2
) (
    input  logic          clk,
    input  logic          rst,
    sw_array_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PARAM, STREAM, DRAIN, REDUCE, DONE} state_t;

    localparam logic [LOG_NUM_PE:0] DRAIN_LAST  = (LOG_NUM_PE+1)'(NUM_PE);
    localparam logic [LOG_NUM_PE:0] REDUCE_LAST = (LOG_NUM_PE+1)'(NUM_PE - 1);

    state_t                     state;
    state_t                     state_next;
    logic [REF_LEN_WIDTH-1:0]   ref_len_q;
    logic [QUERY_LEN_WIDTH-1:0] last_blk_q;
    logic [REF_LEN_WIDTH-1:0]   addr_q;
    logic [LOG_NUM_PE:0]        cnt_q;
    logic [QUERY_LEN_WIDTH-1:0] blk_q;
    logic                       init_q;
    logic                       addr_end;
    logic                       job_zero;

    assign addr_end = (addr_q == ref_len_q - REF_LEN_WIDTH'(1));
    assign job_zero = (bus.ref_len_in == '0) || (bus.query_len_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        bus.ready       = 1'b0;
        bus.busy        = 1'b1;
        bus.set_param   = 1'b0;
        bus.ref_rd_en   = 1'b0;
        bus.compute_max = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                bus.busy  = 1'b0;
                if (bus.start) state_next = job_zero ? DONE : PARAM;
            end
            PARAM: begin
                bus.set_param = 1'b1;
                state_next    = STREAM;
            end
            STREAM: begin
                bus.ref_rd_en = 1'b1;
                if (addr_end) state_next = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_next = (blk_q == last_blk_q) ? REDUCE : PARAM;
            end
            REDUCE: begin
                bus.compute_max = 1'b1;
                if (cnt_q == REDUCE_LAST) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // last_blk_q holds ceil(query_len/NUM_PE)-1 directly, avoiding a wider block count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_len_q            <= '0;
            last_blk_q           <= '0;
            addr_q               <= '0;
            cnt_q                <= '0;
            blk_q                <= '0;
            bus.score_params_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ref_len_q            <= bus.ref_len_in;
                        last_blk_q           <= (bus.query_len_in - QUERY_LEN_WIDTH'(1)) >> LOG_NUM_PE;
                        score_params_latch();
                        addr_q               <= '0;
                        cnt_q                <= '0;
                        blk_q                <= '0;
                    end
                end
                STREAM: addr_q <= addr_end ? '0 : addr_q + REF_LEN_WIDTH'(1);
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q <= '0;
                        if (blk_q != last_blk_q) blk_q <= blk_q + QUERY_LEN_WIDTH'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REDUCE: cnt_q <= (cnt_q == REDUCE_LAST) ? '0 : cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    task automatic score_params_latch();
        bus.score_params_out <= bus.score_params_in;
    endtask

    // The reference buffer already registers its read, so the buffer output is the
    // registered base; only the enable needs a matching delay stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) init_q <= 1'b0;
        else     init_q <= bus.ref_rd_en;
    end

    assign bus.init_out    = init_q;
    assign bus.T_out       = init_q ? bus.ref_rd_data : 3'd0;
    assign bus.ref_rd_addr = addr_q;
    assign bus.block_idx   = blk_q;
    assign bus.last        = (state != IDLE) && (state != DONE) && (blk_q == last_blk_q);
    assign bus.init_V      = '0;
    assign bus.init_E      = {2'b11, {(WIDTH-2){1'b0}}};

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Self-checking bench for sw_array_ctrl: random jobs compared cycle by cycle
// against a timeline model built from block/offset arithmetic.
module tb_sw_array_ctrl;

    localparam int WIDTH  = 10;
    localparam int RLW    = 10;
    localparam int QLW    = 10;
    localparam int NUM_PE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [2:0] mem [0:1023];

    sw_array_ctrl_if #(.WIDTH(WIDTH), .REF_LEN_WIDTH(RLW), .QUERY_LEN_WIDTH(QLW)) bus ();

    sw_array_ctrl #(
        .WIDTH(WIDTH), .REF_LEN_WIDTH(RLW), .QUERY_LEN_WIDTH(QLW),
        .NUM_PE(NUM_PE), .LOG_NUM_PE(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read reference buffer: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (bus.ref_rd_en) bus.ref_rd_data <= mem[bus.ref_rd_addr];
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not reach the end, got stuck, required finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [7:0] ctl_now();
        return {bus.ready, bus.busy, bus.set_param, bus.last,
                bus.ref_rd_en, bus.init_out, bus.compute_max, bus.done};
    endfunction

    // Runs one job starting at the current negedge; checks every cycle through the
    // first idle cycle after done.
    task automatic run_job(input int ref_len, input int query_len, input bit preset, input bit disturb);
        logic [7*WIDTH-1:0] params;
        int nblk, blen, done_cyc, red0, b, o, exp_blk;
        logic [7:0] exp_ctl;
        logic [2:0] exp_t;
        bit zero;
        params[31:0]  = $urandom();
        params[63:32] = $urandom();
        params[69:64] = 6'($urandom());
        if (!preset) for (int i = 0; i < ref_len; i++) mem[i] = 3'($urandom_range(0, 7));
        zero     = (ref_len == 0) || (query_len == 0);
        nblk     = (query_len + NUM_PE - 1) / NUM_PE;
        blen     = ref_len + NUM_PE + 2;
        red0     = 1 + nblk * blen;
        done_cyc = zero ? 1 : red0 + NUM_PE;
        bus.ref_len_in      = RLW'(ref_len);
        bus.query_len_in    = QLW'(query_len);
        bus.score_params_in = params;
        bus.start           = 1'b1;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (disturb && c == 3) begin
                bus.start = 1'b1;
                bus.score_params_in = ~params;
            end
            if (disturb && c == 4) bus.start = 1'b0;
            exp_ctl = 8'b0100_0000;
            exp_t   = 3'd0;
            exp_blk = zero ? 0 : nblk - 1;
            o       = -1;
            if (c == done_cyc + 1) begin
                exp_ctl = 8'b1000_0000;
            end else if (c == done_cyc) begin
                exp_ctl[0] = 1'b1;
            end else if (c >= red0) begin
                exp_ctl[1] = 1'b1;
                exp_ctl[4] = 1'b1;
            end else begin
                b = (c - 1) / blen;
                o = (c - 1) % blen;
                exp_blk    = b;
                exp_ctl[5] = (o == 0);
                exp_ctl[4] = (b == nblk - 1);
                exp_ctl[3] = (o >= 1) && (o <= ref_len);
                exp_ctl[2] = (o >= 2) && (o <= ref_len + 1);
                if (exp_ctl[2]) exp_t = mem[o-2];
            end
            total++;
            if (ctl_now() !== exp_ctl) begin
                bad++;
                if (bad < 40) $display("[TB] FAIL ctl L=%0d Q=%0d cyc=%0d got=%b want=%b (rdy,bsy,set,last,en,init,max,done)",
                                       ref_len, query_len, c, ctl_now(), exp_ctl);
            end
            if (exp_ctl[3]) begin
                total++;
                if (bus.ref_rd_addr !== RLW'(o - 1)) begin
                    bad++;
                    if (bad < 40) $display("[TB] FAIL addr cyc=%0d got=%0d want=%0d", c, bus.ref_rd_addr, o - 1);
                end
            end
            total++;
            if (bus.T_out !== exp_t) begin
                bad++;
                if (bad < 40) $display("[TB] FAIL T_out cyc=%0d got=%0d want=%0d", c, bus.T_out, exp_t);
            end
            total++;
            if (bus.block_idx !== QLW'(exp_blk)) begin
                bad++;
                if (bad < 40) $display("[TB] FAIL block_idx cyc=%0d got=%0d want=%0d", c, bus.block_idx, exp_blk);
            end
            total++;
            if (bus.score_params_out !== params) begin
                bad++;
                if (bad < 40) $display("[TB] FAIL params cyc=%0d got=%h want=%h", c, bus.score_params_out, params);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ctl_now() !== 8'b1000_0000) begin
                bad++;
                $display("[TB] FAIL reset_ctl phase=%0d got=%b want=10000000", k, ctl_now());
            end
            total++;
            if ({bus.ref_rd_addr, bus.T_out, bus.block_idx, bus.init_V} !== '0 || bus.score_params_out !== '0) begin
                bad++;
                $display("[TB] FAIL reset_data phase=%0d addr=%0d T=%0d blk=%0d V=%0d sp=%h want all 0",
                         k, bus.ref_rd_addr, bus.T_out, bus.block_idx, bus.init_V, bus.score_params_out);
            end
            total++;
            if (bus.init_E !== 10'h300) begin
                bad++;
                $display("[TB] FAIL init_E got=%h want=300", bus.init_E);
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_spec_example();
        mem[0] = 3'd1; mem[1] = 3'd2; mem[2] = 3'd3; mem[3] = 3'd4; mem[4] = 3'd0;
        run_job(5, 6, 1'b1, 1'b0);
    endtask

    task automatic test_zero_len();
        run_job(7, 0, 1'b0, 1'b0);
        run_job(0, 9, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(1, 20), $urandom_range(1, 13), 1'b0, 1'b0);
        run_job(1, 4, 1'b0, 1'b0);
        run_job(3, 5, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_job(6, 7, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_stream();
        bus.ref_len_in      = RLW'(8);
        bus.query_len_in    = QLW'(9);
        bus.score_params_in = 70'h1234567;
        bus.start           = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ctl_now() !== 8'b1000_0000) begin
            bad++;
            $display("[TB] FAIL midreset_ctl got=%b want=10000000", ctl_now());
        end
        total++;
        if ({bus.ref_rd_addr, bus.T_out, bus.block_idx} !== '0 || bus.score_params_out !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_data addr=%0d T=%0d blk=%0d sp=%h want all 0",
                     bus.ref_rd_addr, bus.T_out, bus.block_idx, bus.score_params_out);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b0;
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_idle k=%0d done=%b busy=%b want 0 0", k, bus.done, bus.busy);
            end
        end
        run_job(8, 9, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job($urandom_range(1, 10), $urandom_range(1, 9), 1'b0, 1'b0);
        run_job($urandom_range(1, 10), $urandom_range(1, 9), 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);
        run_job(2, 1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.ref_len_in      = '0;
        bus.query_len_in    = '0;
        bus.score_params_in = '0;
        bus.ref_rd_data     = '0;
        test_reset();
        test_spec_example();
        test_zero_len();
        test_random();
        test_ignore_start();
        test_reset_mid_stream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
Sequencer for a linear array of NUM_PE Smith-Waterman processing elements. It accepts one alignment job, splits the query into blocks of NUM_PE rows, and handles each block in order. For each block it pulses parameter load, streams the reference bases from the reference buffer into PE 0, and waits for the wavefront to drain. After the final block it runs the max-reduction pass and signals completion. It sits between the job/host interface and the PE chain, and owns set_param, last, init, T and compute_max for PE 0.

Parameters:
WIDTH, 10, score width; also the width of each scoring field.
REF_LEN_WIDTH, 10, width of the reference length and reference address.
QUERY_LEN_WIDTH, 10, width of the query length.
NUM_PE, 4, number of PEs in the chain.
LOG_NUM_PE, 2, log2(NUM_PE).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  job request; sampled only while ready=1
ready  out  1  high in IDLE
busy  out  1  high in any state other than IDLE
ref_len_in  in  REF_LEN_WIDTH  reference length in bases
query_len_in  in  QUERY_LEN_WIDTH  query length in bases
score_params_in  in  7*WIDTH  {sub_A,sub_C,sub_G,sub_T,sub_N,gap_open,gap_extend}
score_params_out  out  7*WIDTH  latched copy of score_params_in, fanned out to all PEs
set_param  out  1  parameter/query-row load pulse to the PEs
last  out  1  current block is the final query block
ref_rd_en  out  1  reference buffer read enable
ref_rd_addr  out  REF_LEN_WIDTH  reference buffer read address
ref_rd_data  in  3  base code; valid 1 cycle after ref_rd_en
T_out  out  3  base code to PE 0
init_out  out  1  computation-active flag to PE 0
init_V  out  WIDTH  V boundary value (0)
init_E  out  WIDTH  E boundary value (2'b11 << (WIDTH-2))
compute_max  out  1  max-reduction enable to PE 0
block_idx  out  QUERY_LEN_WIDTH  index of the current query block
done  out  1  1-cycle completion pulse

Behaviour:
- Reset (asynchronous): state goes to IDLE; all outputs and counters go to 0 except ready=1. init_E is a constant and is unaffected by reset. Reset asserted mid-job abandons the job immediately, with no done pulse.
- States: IDLE, PARAM, STREAM, DRAIN, REDUCE, DONE.
- IDLE, start=1: latch ref_len, query_len and score_params. nblk = ceil(query_len/NUM_PE). block_idx=0.
  - If ref_len==0 or query_len==0: go to DONE.
  - Otherwise: go to PARAM.
- start is ignored while busy.
- PARAM: set_param=1 for exactly 1 cycle. last=1 if block_idx==nblk-1. Next state is STREAM, with the address counter at 0.
- STREAM: ref_rd_en=1 and ref_rd_addr=0..ref_len-1, one address per cycle, for exactly ref_len cycles. Then go to DRAIN.
- T_out and init_out: registered copies of ref_rd_data and ref_rd_en, so init_out is ref_rd_en delayed by 1 cycle. T_out=0 whenever init_out=0.
- DRAIN: lasts NUM_PE+1 cycles, counted from the cycle after the final ref_rd_en. init_out is high in the first of these cycles only.
  - If block_idx<nblk-1: increment block_idx and go to PARAM.
  - Otherwise: go to REDUCE.
- REDUCE: compute_max=1 for exactly NUM_PE cycles, then go to DONE.
- DONE: done=1 for 1 cycle, then go to IDLE.
- last: held high from the PARAM cycle of the final block through the end of REDUCE. Cleared in DONE.
- Mutual exclusion: set_param, init_out and compute_max are never high in the same cycle.
- Block length is 2 + ref_len + NUM_PE cycles.
- Counters: the address counter never exceeds ref_len-1. block_idx wraps only on a new job.
- query_len not a multiple of NUM_PE: the final block is still a full NUM_PE-row pass. Unused PE rows are the PEs' responsibility via last.

Test Plan:
- Reset then idle -> ready=1, busy=0, every other output 0, init_E=0x300 (WIDTH=10).
- ref_len=5, query_len=6, NUM_PE=4, start at edge 0 -> set_param high in cycles 1 and 12; ref_rd_addr 0..4 in cycles 2–6 and 13–17; init_out high in cycles 3–7 and 14–18; last high from cycle 12 through cycle 26; compute_max high in cycles 23–26; done in cycle 27.
- Reference buffer returns bases 1,2,3,4,0 -> T_out is 1,2,3,4,0 in the same cycles init_out is high, and 0 at all other times.
- query_len=0 or ref_len=0 -> done high in cycle 1; set_param, ref_rd_en and compute_max never asserted.
- start pulsed mid-job, then score_params_in changed mid-job -> both ignored; score_params_out keeps the values latched at acceptance.
- rst asserted during STREAM -> outputs clear asynchronously in the same cycle, no done pulse; a new start after reset runs a full, correct job.
